// File: rtl/apple_spawner.sv
// apple_spawner: LFSR-driven apple placement on a 40x30 grid, validated against the snake occupancy table.
// Optional raster-scan fallback and board-full detection enabled by APPLE_SCAN_FALLBACK_EN.
module apple_spawner #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          INIT_COL  = 20,
    parameter int          INIT_ROW  = 15,
    parameter int          MAX_TRIES = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       eat,
    output logic       occ_req,
    output logic [5:0] occ_col,
    output logic [4:0] occ_row,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [9:0] AppleX,
    output logic [9:0] AppleY,
    output logic       apple_valid,
    output logic       board_full,
    output logic [7:0] spawn_count
);
    typedef enum logic [2:0] {IDLE, DRAW, CHECK, COMMIT, SCAN, SGAP, FULL} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  occ_col_q, occ_col_d, apple_col_q, apple_col_d;
    logic [4:0]  occ_row_q, occ_row_d, apple_row_q, apple_row_d;
    logic [7:0]  tries_q, tries_d, spawn_q, spawn_d;
    logic        cand_ok, is_apple, reject;

    assign cand_ok  = (lfsr_q[5:0] < 6'd40) && (lfsr_q[12:8] < 5'd30);
    assign is_apple = (occ_col_q == apple_col_q) && (occ_row_q == apple_row_q);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        occ_col_d   = occ_col_q;
        occ_row_d   = occ_row_q;
        apple_col_d = apple_col_q;
        apple_row_d = apple_row_q;
        tries_d     = tries_q;
        spawn_d     = spawn_q;
        reject      = 1'b0;
        case (state_q)
            IDLE: begin
                if (eat) begin
                    state_d = DRAW;
                    tries_d = 8'd0;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    occ_col_d = lfsr_q[5:0];
                    occ_row_d = lfsr_q[12:8];
                    state_d   = CHECK;
                end else begin
                    reject = 1'b1;
                end
            end
            CHECK: begin
                if (occ_ack) begin
                    if (occ_hit || is_apple) reject = 1'b1;
                    else state_d = COMMIT;
                end
            end
            COMMIT: begin
                apple_col_d = occ_col_q;
                apple_row_d = occ_row_q;
                spawn_d     = spawn_q + 8'd1;
                state_d     = IDLE;
            end
`ifdef APPLE_SCAN_FALLBACK_EN
            SCAN: begin
                if (occ_ack) begin
                    if (!(occ_hit || is_apple)) begin
                        state_d = COMMIT;
                    end else if (occ_col_q == 6'd39 && occ_row_q == 5'd29) begin
                        state_d = FULL;
                    end else begin
                        state_d   = SGAP;
                        occ_col_d = (occ_col_q == 6'd39) ? 6'd0 : occ_col_q + 6'd1;
                        occ_row_d = (occ_col_q == 6'd39) ? occ_row_q + 5'd1 : occ_row_q;
                    end
                end
            end
            SGAP:    state_d = SCAN;
            FULL:    state_d = FULL;
`endif
            default: state_d = IDLE;
        endcase
`ifdef APPLE_SCAN_FALLBACK_EN
        // Once the random search has burned its budget, fall back to a deterministic sweep.
        if (reject) begin
            tries_d = tries_q + 8'd1;
            if (tries_d >= 8'(MAX_TRIES)) begin
                state_d   = SCAN;
                occ_col_d = 6'd0;
                occ_row_d = 5'd0;
            end else begin
                state_d = DRAW;
            end
        end
`else
        if (reject) begin
            tries_d = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
            state_d = DRAW;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            occ_col_q   <= 6'd0;
            occ_row_q   <= 5'd0;
            apple_col_q <= 6'(INIT_COL);
            apple_row_q <= 5'(INIT_ROW);
            tries_q     <= 8'd0;
            spawn_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            occ_col_q   <= occ_col_d;
            occ_row_q   <= occ_row_d;
            apple_col_q <= apple_col_d;
            apple_row_q <= apple_row_d;
            tries_q     <= tries_d;
            spawn_q     <= spawn_d;
        end
    end

    assign occ_req     = (state_q == CHECK) || (state_q == SCAN);
    assign occ_col     = occ_col_q;
    assign occ_row     = occ_row_q;
    assign AppleX      = {apple_col_q, 4'b0000};
    assign AppleY      = {1'b0, apple_row_q, 4'b0000};
    assign apple_valid = (state_q == IDLE);
    assign spawn_count = spawn_q;
`ifdef APPLE_SCAN_FALLBACK_EN
    assign board_full  = (state_q == FULL);
`else
    assign board_full  = 1'b0;
`endif
endmodule

// File: tb/tb_apple_spawner.sv
// tb_apple_spawner: directed checks of apple_spawner against an occupancy responder and an LFSR reference.
module tb_apple_spawner;
    logic       Clk = 1'b0, Reset = 1'b1, eat = 1'b0, occ_ack = 1'b0, occ_hit = 1'b0;
    logic       occ_req, apple_valid, board_full;
    logic [5:0] occ_col;
    logic [4:0] occ_row;
    logic [9:0] AppleX, AppleY;
    logic [7:0] spawn_count;

    int n_cmp = 0, n_err = 0;
    int resp_delay = 0, hits_left = 0, wait_cnt = 0, n_req = 0, unstable = 0, bad_range = 0;
    int free_col = -1, free_row = -1;
    bit hit_all = 0, acked = 0;
    logic [5:0] req_col, last_col, first_col, exp_col = 6'd20;
    logic [4:0] req_row, last_row, first_row, exp_row = 5'd15;
    logic [15:0] m_lfsr;

    apple_spawner dut (
        .Clk(Clk), .Reset(Reset), .eat(eat),
        .occ_req(occ_req), .occ_col(occ_col), .occ_row(occ_row),
        .occ_ack(occ_ack), .occ_hit(occ_hit),
        .AppleX(AppleX), .AppleY(AppleY), .apple_valid(apple_valid),
        .board_full(board_full), .spawn_count(spawn_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge Clk) m_lfsr <= Reset ? 16'hACE1 : lfsr_next(m_lfsr);

    task automatic responder();
        forever begin
            @(negedge Clk);
            if (occ_req && !acked) begin
                if (wait_cnt == 0) begin
                    req_col = occ_col;
                    req_row = occ_row;
                    if (occ_col >= 6'd40 || occ_row >= 5'd30) bad_range++;
                end else if (occ_col != req_col || occ_row != req_row) begin
                    unstable++;
                end
                if (wait_cnt == resp_delay) begin
                    if (n_req == 0) begin
                        first_col = occ_col;
                        first_row = occ_row;
                    end
                    n_req++;
                    last_col = occ_col;
                    last_row = occ_row;
                    occ_ack  = 1'b1;
                    occ_hit  = hit_all ? !(int'(occ_col) == free_col && int'(occ_row) == free_row) : (hits_left > 0);
                    if (!hit_all && hits_left > 0) hits_left--;
                    acked = 1;
                end else begin
                    occ_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                occ_ack = 1'b0;
                occ_hit = 1'b0;
                if (!occ_req) begin
                    acked    = 0;
                    wait_cnt = 0;
                end
            end
        end
    endtask

    // Pulse eat in a cycle whose following DRAW sample is an in-range, non-apple cell.
    task automatic pulse_eat_good(output logic [5:0] c_col, output logic [4:0] c_row);
        logic [15:0] c;
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            c = lfsr_next(m_lfsr);
            if (c[5:0] < 6'd40 && c[12:8] < 5'd30 && !(c[5:0] == exp_col && c[12:8] == exp_row)) found = 1;
            else @(negedge Clk);
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL eat_slot: no usable LFSR slot found, got %0d required 1", found);
        end
        c_col = c[5:0];
        c_row = c[12:8];
        eat = 1'b1;
        @(negedge Clk);
        eat = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge Clk);
            ok = apple_valid;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout: apple_valid=%0d required 1 within %0d cycles", name, apple_valid, max_cycles);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        exp_col = 6'd20;
        exp_row = 5'd15;
        n_cmp++; if (AppleX !== 10'd320) begin n_err++; $display("FAIL reset_x: got %0d required 320", AppleX); end
        n_cmp++; if (AppleY !== 10'd240) begin n_err++; $display("FAIL reset_y: got %0d required 240", AppleY); end
        n_cmp++; if (apple_valid !== 1'b1) begin n_err++; $display("FAIL reset_valid: got %0d required 1", apple_valid); end
        n_cmp++; if (spawn_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", spawn_count); end
        n_cmp++; if (occ_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0d required 0", occ_req); end
        n_cmp++; if (board_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0d required 0", board_full); end
        n_cmp++; if (occ_col !== 6'd0 || occ_row !== 5'd0) begin n_err++; $display("FAIL reset_occ: got %0d,%0d required 0,0", occ_col, occ_row); end
    endtask

    task automatic test_immediate_commit();
        logic [5:0] c_col;
        logic [4:0] c_row;
        resp_delay = 0; hits_left = 0; hit_all = 0;
        pulse_eat_good(c_col, c_row);
        n_cmp++; if (apple_valid !== 1'b0 || occ_req !== 1'b0) begin n_err++; $display("FAIL imm_c1: valid=%0d req=%0d required 0,0", apple_valid, occ_req); end
        @(negedge Clk);
        n_cmp++; if (occ_req !== 1'b1 || apple_valid !== 1'b0) begin n_err++; $display("FAIL imm_c2: req=%0d valid=%0d required 1,0", occ_req, apple_valid); end
        n_cmp++; if (occ_col !== c_col || occ_row !== c_row) begin n_err++; $display("FAIL imm_cand: got %0d,%0d required %0d,%0d", occ_col, occ_row, c_col, c_row); end
        @(negedge Clk);
        n_cmp++; if (apple_valid !== 1'b0 || occ_req !== 1'b0) begin n_err++; $display("FAIL imm_c3: valid=%0d req=%0d required 0,0", apple_valid, occ_req); end
        @(negedge Clk);
        n_cmp++; if (apple_valid !== 1'b1) begin n_err++; $display("FAIL imm_c4: valid=%0d required 1", apple_valid); end
        n_cmp++; if (AppleX !== {c_col, 4'b0} || AppleY !== {1'b0, c_row, 4'b0}) begin n_err++; $display("FAIL imm_pos: got %0d,%0d required %0d,%0d", AppleX, AppleY, {c_col, 4'b0}, {1'b0, c_row, 4'b0}); end
        n_cmp++; if (AppleX == 10'd320 && AppleY == 10'd240) begin n_err++; $display("FAIL imm_moved: got %0d,%0d required not 320,240", AppleX, AppleY); end
        n_cmp++; if (spawn_count !== 8'd1) begin n_err++; $display("FAIL imm_count: got %0d required 1", spawn_count); end
        exp_col = c_col;
        exp_row = c_row;
    endtask

    task automatic test_slow_busy();
        logic [5:0] c_col;
        logic [4:0] c_row;
        n_req = 0; unstable = 0; bad_range = 0;
        resp_delay = 5; hits_left = 3; hit_all = 0;
        pulse_eat_good(c_col, c_row);
        wait_valid(600, "slow");
        repeat (3) @(negedge Clk);
        n_cmp++; if (n_req != 4) begin n_err++; $display("FAIL slow_reqs: got %0d required 4", n_req); end
        n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL slow_stable: got %0d unstable cycles required 0", unstable); end
        n_cmp++; if (bad_range != 0) begin n_err++; $display("FAIL slow_range: got %0d out-of-range queries required 0", bad_range); end
        n_cmp++; if (first_col !== c_col || first_row !== c_row) begin n_err++; $display("FAIL slow_first: got %0d,%0d required %0d,%0d", first_col, first_row, c_col, c_row); end
        n_cmp++; if (AppleX !== {last_col, 4'b0} || AppleY !== {1'b0, last_row, 4'b0}) begin n_err++; $display("FAIL slow_pos: got %0d,%0d required %0d,%0d", AppleX, AppleY, {last_col, 4'b0}, {1'b0, last_row, 4'b0}); end
        n_cmp++; if (spawn_count !== 8'd2) begin n_err++; $display("FAIL slow_count: got %0d required 2", spawn_count); end
        exp_col = last_col;
        exp_row = last_row;
    endtask

    task automatic test_reset_mid_search();
        logic [5:0] c_col;
        logic [4:0] c_row;
        resp_delay = 50; hits_left = 0; hit_all = 0;
        pulse_eat_good(c_col, c_row);
        for (int i = 0; i < 10 && !occ_req; i++) @(negedge Clk);
        n_cmp++; if (occ_req !== 1'b1) begin n_err++; $display("FAIL mid_req_up: got %0d required 1", occ_req); end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_cmp++; if (occ_req !== 1'b0) begin n_err++; $display("FAIL mid_req_drop: got %0d required 0", occ_req); end
        n_cmp++; if (AppleX !== 10'd320 || AppleY !== 10'd240) begin n_err++; $display("FAIL mid_pos: got %0d,%0d required 320,240", AppleX, AppleY); end
        n_cmp++; if (apple_valid !== 1'b1 || spawn_count !== 8'd0) begin n_err++; $display("FAIL mid_state: valid=%0d count=%0d required 1,0", apple_valid, spawn_count); end
        exp_col = 6'd20;
        exp_row = 5'd15;
        @(negedge Clk);
    endtask

    task automatic test_eat_ignored();
        logic [5:0] c_col;
        logic [4:0] c_row;
        logic [7:0] sc;
        resp_delay = 3; hits_left = 0; hit_all = 0;
        sc = spawn_count;
        pulse_eat_good(c_col, c_row);
        eat = 1'b1;
        repeat (6) @(negedge Clk);
        eat = 1'b0;
        n_cmp++; if (apple_valid !== 1'b1) begin n_err++; $display("FAIL ign_valid: got %0d required 1", apple_valid); end
        n_cmp++; if (spawn_count !== sc + 8'd1) begin n_err++; $display("FAIL ign_count: got %0d required %0d", spawn_count, sc + 8'd1); end
        n_cmp++; if (AppleX !== {c_col, 4'b0} || AppleY !== {1'b0, c_row, 4'b0}) begin n_err++; $display("FAIL ign_pos: got %0d,%0d required %0d,%0d", AppleX, AppleY, {c_col, 4'b0}, {1'b0, c_row, 4'b0}); end
        @(negedge Clk);
        n_cmp++; if (apple_valid !== 1'b1) begin n_err++; $display("FAIL ign_commit_eat: valid=%0d required 1", apple_valid); end
        repeat (10) @(negedge Clk);
        n_cmp++; if (spawn_count !== sc + 8'd1) begin n_err++; $display("FAIL ign_count_late: got %0d required %0d", spawn_count, sc + 8'd1); end
        exp_col = c_col;
        exp_row = c_row;
    endtask

`ifdef APPLE_SCAN_FALLBACK_EN
    task automatic test_scan_fallback();
        logic [5:0] c_col;
        logic [4:0] c_row;
        resp_delay = 0; hit_all = 1; free_col = 3; free_row = 0;
        pulse_eat_good(c_col, c_row);
        wait_valid(20000, "scan");
        n_cmp++; if (AppleX !== 10'd48 || AppleY !== 10'd0) begin n_err++; $display("FAIL scan_pos: got %0d,%0d required 48,0", AppleX, AppleY); end
        n_cmp++; if (board_full !== 1'b0) begin n_err++; $display("FAIL scan_full: got %0d required 0", board_full); end
        exp_col = 6'd3;
        exp_row = 5'd0;
    endtask

    task automatic test_full_board();
        logic [5:0] c_col;
        logic [4:0] c_row;
        resp_delay = 0; hit_all = 1; free_col = -1; free_row = -1;
        pulse_eat_good(c_col, c_row);
        for (int i = 0; i < 20000 && !board_full; i++) @(negedge Clk);
        n_cmp++; if (board_full !== 1'b1 || apple_valid !== 1'b0) begin n_err++; $display("FAIL full_set: full=%0d valid=%0d required 1,0", board_full, apple_valid); end
        n_cmp++; if (last_col !== 6'd39 || last_row !== 5'd29) begin n_err++; $display("FAIL full_last: got %0d,%0d required 39,29", last_col, last_row); end
        repeat (1000) @(negedge Clk);
        n_cmp++; if (board_full !== 1'b1 || apple_valid !== 1'b0 || occ_req !== 1'b0) begin n_err++; $display("FAIL full_hold: full=%0d valid=%0d req=%0d required 1,0,0", board_full, apple_valid, occ_req); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        fork responder(); join_none
        test_reset();
        test_immediate_commit();
        test_slow_busy();
        test_reset_mid_search();
        test_eat_ignored();
`ifdef APPLE_SCAN_FALLBACK_EN
        test_reset();
        test_scan_fallback();
        test_full_board();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
